pi_rx_nibble_streamer: RTL

Receive-path output stage between the receiver sample mux and the Raspberry Pi RX IQ port. Buffers 48-bit IQ sample words ({I[23:0], Q[23:0]}) in a small FIFO and serialises them MSB-first as 4-bit nibbles on `pi_rx_data`, advanced by rising edges of the Pi-driven `pi_rx_clk`. `pi_rx_clk` is oversampled in the system clock domain. `pi_rx_samples` frames bursts of THRESH words, so the Pi reads only when a full burst is buffered.

---
 rtl/pi_rx_nibble_streamer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pi_rx_nibble_streamer.sv
// RX IQ output stage: buffers 48-bit IQ words and streams them
// MSB-first as nibbles, stepped by rising edges of the Pi strobe.
module pi_rx_nibble_streamer #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [47:0]             rx_tdata,
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  input  logic                    pi_rx_clk,
  output logic                    pi_rx_samples,
  output logic [3:0]              pi_rx_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (THRESH > 1) ? $clog2(THRESH) : 1;
  localparam logic [WW-1:0] WLAST = WW'(THRESH - 1);

  typedef enum logic {
    S_WAIT,
    S_BURST
  } state_t;

  state_t state_q, state_d;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [7:0]    ovf_q, ovf_d;

  logic          s1_q, s2_q, s3_q;
  logic [47:0]   sh_q, sh_d;
  logic [3:0]    n_q, n_d;
  logic [WW-1:0] w_q, w_d;
  logic [3:0]    dat_q, dat_d;

  logic full;
  logic push;
  logic pop;
  logic re;

  assign full      = (lvl_q == LW'(DEPTH));
  assign rx_tready = !rst && !full;
  assign push      = rx_tvalid && rx_tready;
  assign re        = s2_q && !s3_q;

  assign pi_rx_samples = (state_q == S_BURST);
  assign pi_rx_data    = dat_q;
  assign level         = lvl_q;
  assign ovf_count     = ovf_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    ovf_d = ovf_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    if (rx_tvalid && !rx_tready && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

  // The shifter holds the remaining nibbles left-aligned,
  // so the presented nibble is always the top one.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    n_d     = n_q;
    w_d     = w_q;
    dat_d   = dat_q;
    pop     = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (lvl_q >= LW'(THRESH)) begin
          pop     = 1'b1;
          sh_d    = mem[rp_q];
          n_d     = 4'd0;
          w_d     = '0;
          dat_d   = sh_d[47:44];
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (re) begin
          if (n_q != 4'd11) begin
            n_d   = n_q + 4'd1;
            sh_d  = sh_q << 4;
            dat_d = sh_d[47:44];
          end else if (w_q != WLAST) begin
            pop   = 1'b1;
            sh_d  = mem[rp_q];
            n_d   = 4'd0;
            w_d   = w_q + WW'(1);
            dat_d = sh_d[47:44];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= rx_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      sh_q    <= '0;
      n_q     <= '0;
      w_q     <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      s1_q    <= pi_rx_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      sh_q    <= sh_d;
      n_q     <= n_d;
      w_q     <= w_d;
      dat_q   <= dat_d;
    end
  end

endmodule
